flash_arbiter: RTL and testbench
================================

FLASH_ARBITER -- requirements
Module: flash_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 24, width of flash byte address.
REQ-002 SHALL have parameter MAX_BURST, default 256, maximum consecutive bytes served to one owner while the other requester waits (range 1..65535).
REQ-003 SHALL have ports, one per line:
- clock  in  1  system clock; one clock domain only.
- reset  in  1  synchronous, active-high reset.
- r0_valid  in  1  requester 0 (game loader) read request, held until r0_ready.
- r0_addr  in  ADDR_W  requester 0 byte address, stable while r0_valid.
- r0_ready  out  1  one-cycle pulse; rdata holds requester 0 byte.
- r1_valid  in  1  requester 1 (auxiliary/save streamer) read request.
- r1_addr  in  ADDR_W  requester 1 byte address.
- r1_ready  out  1  one-cycle pulse for requester 1.
- rdata  out  8  byte from flash controller, valid only in a cycle where a ready pulses.
- mem_valid  out  1  to flashmem valid.
- mem_addr  out  ADDR_W  to flashmem addr.
- mem_ready  in  1  flashmem one-cycle completion pulse.
- mem_rdata  in  8  flashmem read data.
- owner  out  1  current/last grant holder, debug.

Function
REQ-004 SHALL implement states IDLE, XFER, SWITCH.
REQ-005 IDLE: if exactly one rN_valid, latch owner=N, go XFER next cycle; if both, grant the requester that is not the last owner (round robin); else stay.
REQ-006 XFER: mem_valid=1, mem_addr=owner's rN_addr combinationally muxed by registered owner; mem_valid SHALL be driven from registered state only.
REQ-007 XFER, mem_ready=1: pulse owner's rN_ready in the same cycle, pass mem_rdata to rdata combinationally, increment 16-bit burst counter.
REQ-008 After a completion: if other requester valid and burst counter reached MAX_BURST, go SWITCH; else if owner still valid, stay XFER (back-to-back, no gap); else if other valid, go SWITCH; else go IDLE.
REQ-009 SWITCH: mem_valid=0 for exactly one cycle, toggle owner, clear burst counter, go XFER; if the new owner dropped valid, go IDLE instead.
REQ-010 Burst counter SHALL saturate at MAX_BURST and clear on every owner change and on entry to IDLE.
REQ-011 Non-owner rN_ready SHALL never pulse; mem_ready outside XFER SHALL be ignored.
REQ-012 Requester dropping rN_valid while owner mid-transfer is a protocol error; arbiter SHALL keep mem_valid high until mem_ready, then discard the byte (no ready pulse).
REQ-013 Single requester alone SHALL never be throttled by MAX_BURST.

Reset
REQ-014 Reset SHALL force IDLE, owner=1 (so requester 0 wins first tie), burst counter 0, mem_valid=0, r0_ready=0, r1_ready=0.
REQ-015 Reset asserted mid-XFER SHALL drop mem_valid the next cycle; flashmem shares the same reset.

Configuration
REQ-016 Macro FLASH_ARB_STATS_EN: when defined, add outputs grants0 and grants1 (32-bit, wrapping) counting ready pulses per requester, cleared by reset; when undefined, ports and counters are absent and behaviour is otherwise identical.

Structure
REQ-017 Shared package flash_pkg SHALL hold the state enum, FLASH_ADDR_W=24, and FLASH_GAME_BASE=24'h400000.
REQ-018 No sub-module; a single flat module of 120-250 lines.

Verification
REQ-019 Only r0 requests addr 0x400000..0x4003FF continuously, mem_ready every 4 cycles -> 1024 r0_ready pulses, no SWITCH, mem_valid never drops.
REQ-020 Both valid from reset -> r0 granted first; MAX_BURST=4 -> ready pattern 0,0,0,0,1,1,1,1,0..., mem_valid low exactly 1 cycle at each switch.
REQ-021 r1 asserts during r0 burst of MAX_BURST=256 -> r1 waits exactly until r0's 256th byte, then SWITCH, then r1 served.
REQ-022 r0 drops valid mid-transfer -> mem_valid held until mem_ready, byte discarded, no r0_ready, IDLE next.
REQ-023 Reset asserted during XFER with r1 owner -> next cycle mem_valid=0, state IDLE, owner=1; ready pulses absent.
REQ-024 With FLASH_ARB_STATS_EN, scenario REQ-020 for 16 bytes -> grants0=8, grants1=8.

Source files
------------

// File: rtl/flash_pkg.sv
// Shared types and constants for the flash read arbiter.
// Holds the arbiter state encoding, default flash address width and game image base.
// No logic; imported by the arbiter and its testbench.
package flash_pkg;

    localparam int FLASH_ADDR_W = 24;
    localparam logic [FLASH_ADDR_W-1:0] FLASH_GAME_BASE = 24'h400000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_XFER   = 2'd1,
        ST_SWITCH = 2'd2
    } flash_state_t;

endpackage

// File: rtl/flash_arbiter.sv
// Two-requester round-robin arbiter in front of a single-byte flash read port.
// Latency: grant one cycle after request; ready pulses combinationally with mem_ready.
// Backpressure: requesters hold valid until their ready; one idle cycle per owner switch.
// Optional FLASH_ARB_STATS_EN adds 32-bit per-requester grant counters.
module flash_arbiter
    import flash_pkg::*;
#(
    parameter int ADDR_W    = FLASH_ADDR_W,
    parameter int MAX_BURST = 256
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              r0_valid,
    input  logic [ADDR_W-1:0] r0_addr,
    output logic              r0_ready,
    input  logic              r1_valid,
    input  logic [ADDR_W-1:0] r1_addr,
    output logic              r1_ready,
    output logic [7:0]        rdata,
    output logic              mem_valid,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [7:0]        mem_rdata,
    output logic              owner
`ifdef FLASH_ARB_STATS_EN
    ,
    output logic [31:0]       grants0,
    output logic [31:0]       grants1
`endif
);

    localparam logic [15:0] LP_MAX_BURST = 16'(MAX_BURST);

    flash_state_t r_state;
    flash_state_t w_state_nxt;
    logic         r_owner;
    logic         w_owner_nxt;
    logic [15:0]  r_burst;
    logic [15:0]  w_burst_nxt;
    logic [15:0]  w_burst_inc;
    logic         w_own_vld;
    logic         w_oth_vld;
    logic         w_done;

    // The flash request is a pure function of registered state; only the address follows the live input.
    assign mem_valid = (r_state == ST_XFER);
    assign mem_addr  = r_owner ? r1_addr : r0_addr;
    assign rdata     = mem_rdata;
    assign owner     = r_owner;

    assign w_own_vld   = r_owner ? r1_valid : r0_valid;
    assign w_oth_vld   = r_owner ? r0_valid : r1_valid;
    assign w_done      = (r_state == ST_XFER) && mem_ready;
    assign w_burst_inc = (r_burst >= LP_MAX_BURST) ? LP_MAX_BURST : r_burst + 16'd1;

    // A completed byte is handed only to the owner, and only if it is still asking (dropped requests lose the byte).
    assign r0_ready = w_done && !r_owner && r0_valid && !reset;
    assign r1_ready = w_done &&  r_owner && r1_valid && !reset;

    // Next-state, owner and burst-count decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_burst_nxt = r_burst;
        case (r_state)
            ST_IDLE: begin
                w_burst_nxt = '0;
                if (r0_valid && r1_valid) begin
                    // Tie goes to whoever did not hold the port last.
                    w_owner_nxt = ~r_owner;
                    w_state_nxt = ST_XFER;
                end else if (r0_valid) begin
                    w_owner_nxt = 1'b0;
                    w_state_nxt = ST_XFER;
                end else if (r1_valid) begin
                    w_owner_nxt = 1'b1;
                    w_state_nxt = ST_XFER;
                end
            end
            ST_XFER: begin
                if (mem_ready) begin
                    w_burst_nxt = w_burst_inc;
                    // Burst limit only matters when someone else is waiting.
                    if (w_oth_vld && (w_burst_inc == LP_MAX_BURST)) begin
                        w_state_nxt = ST_SWITCH;
                    end else if (w_own_vld) begin
                        w_state_nxt = ST_XFER;
                    end else if (w_oth_vld) begin
                        w_state_nxt = ST_SWITCH;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_burst_nxt = '0;
                    end
                end
            end
            ST_SWITCH: begin
                w_owner_nxt = ~r_owner;
                w_burst_nxt = '0;
                // The incoming owner is the "other" side relative to the current r_owner.
                w_state_nxt = w_oth_vld ? ST_XFER : ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_burst_nxt = '0;
            end
        endcase
    end

    // State, owner and burst registers; owner resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_owner <= 1'b1;
            r_burst <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_burst <= w_burst_nxt;
        end
    end

`ifdef FLASH_ARB_STATS_EN
    logic [31:0] r_grants0;
    logic [31:0] r_grants1;

    // Wrapping per-requester counts of delivered bytes.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_grants0 <= '0;
            r_grants1 <= '0;
        end else begin
            if (r0_ready) r_grants0 <= r_grants0 + 32'd1;
            if (r1_ready) r_grants1 <= r_grants1 + 32'd1;
        end
    end

    assign grants0 = r_grants0;
    assign grants1 = r_grants1;
`endif

endmodule

// File: tb/tb_flash_arbiter.sv
// Randomized testbench for flash_arbiter against a cycle-level behavioural model.
// Drives inputs 1 time unit after the rising edge, checks outputs on the falling edge.
// Directed phases cover streaming, tie/round-robin bursts, dropped requests and reset.
module tb_flash_arbiter;
    import flash_pkg::*;

    localparam int AW = 24;
    localparam int MB = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          r0_valid, r1_valid;
    logic [AW-1:0] r0_addr, r1_addr;
    logic          r0_ready, r1_ready;
    logic [7:0]    rdata;
    logic          mem_valid;
    logic [AW-1:0] mem_addr;
    logic          mem_ready;
    logic [7:0]    mem_rdata;
    logic          owner;
`ifdef FLASH_ARB_STATS_EN
    logic [31:0]   grants0, grants1;
`endif

    always #5 clock = ~clock;

    flash_arbiter #(.ADDR_W(AW), .MAX_BURST(MB)) dut (
        .clock     (clock),
        .reset     (reset),
        .r0_valid  (r0_valid),
        .r0_addr   (r0_addr),
        .r0_ready  (r0_ready),
        .r1_valid  (r1_valid),
        .r1_addr   (r1_addr),
        .r1_ready  (r1_ready),
        .rdata     (rdata),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .owner     (owner)
`ifdef FLASH_ARB_STATS_EN
        ,
        .grants0   (grants0),
        .grants1   (grants1)
`endif
    );

    // Model: m_st 0 = nobody served, 1 = serving m_own, 2 = one-cycle handover gap.
    int m_st, m_own, m_cnt, m_g0, m_g1;
    bit e0, e1;
    int n_cmp, n_bad;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_cycle();
        @(negedge clock);
        e0 = (m_st == 1) && mem_ready && (m_own == 0) && r0_valid && !reset;
        e1 = (m_st == 1) && mem_ready && (m_own == 1) && r1_valid && !reset;
        chk("mem_valid", 32'(mem_valid), 32'(m_st == 1));
        if (m_st == 1) chk("mem_addr", 32'(mem_addr), 32'((m_own == 1) ? r1_addr : r0_addr));
        chk("r0_ready", 32'(r0_ready), 32'(e0));
        chk("r1_ready", 32'(r1_ready), 32'(e1));
        if (e0 || e1) chk("rdata", 32'(rdata), 32'(mem_rdata));
        chk("owner", 32'(owner), 32'(m_own));
`ifdef FLASH_ARB_STATS_EN
        chk("grants0", grants0, 32'(m_g0));
        chk("grants1", grants1, 32'(m_g1));
`endif
    endtask

    task automatic model_update();
        bit ov, sv;
        if (reset) begin
            m_st = 0; m_own = 1; m_cnt = 0; m_g0 = 0; m_g1 = 0;
        end else begin
            if (e0) m_g0++;
            if (e1) m_g1++;
            ov = (m_own == 1) ? r1_valid : r0_valid;
            sv = (m_own == 1) ? r0_valid : r1_valid;
            case (m_st)
                0: begin
                    m_cnt = 0;
                    if (r0_valid && r1_valid) begin m_own = 1 - m_own; m_st = 1; end
                    else if (r0_valid)        begin m_own = 0;         m_st = 1; end
                    else if (r1_valid)        begin m_own = 1;         m_st = 1; end
                end
                1: if (mem_ready) begin
                    if (m_cnt < MB) m_cnt++;
                    if (sv && m_cnt == MB) m_st = 2;
                    else if (ov)           m_st = 1;
                    else if (sv)           m_st = 2;
                    else begin m_st = 0; m_cnt = 0; end
                end
                default: begin
                    m_own = 1 - m_own;
                    m_cnt = 0;
                    m_st  = ((m_own == 1) ? r1_valid : r0_valid) ? 1 : 0;
                end
            endcase
        end
    endtask

    task automatic cycle();
        check_cycle();
        @(posedge clock);
        model_update();
        #1;
    endtask

    initial begin
        int np, drops, lows;
        int seq[$];
        n_cmp = 0; n_bad = 0; e0 = 0; e1 = 0;
        m_st = 0; m_own = 1; m_cnt = 0; m_g0 = 0; m_g1 = 0;
        reset = 1; r0_valid = 0; r1_valid = 0; r0_addr = '0; r1_addr = '0;
        mem_ready = 0; mem_rdata = '0;
        @(posedge clock); model_update(); #1;
        cycle();
        cycle();

        // Phase A: r0 streams the game image alone, flash answers every 4th cycle.
        reset = 0; r0_valid = 1; r0_addr = FLASH_GAME_BASE;
        np = 0; drops = 0;
        for (int cyc = 0; cyc < 6000 && np < 1024; cyc++) begin
            mem_ready = (m_st == 1) && (cyc % 4 == 3);
            mem_rdata = 8'($urandom);
            cycle();
            if (e0) begin
                np++;
                r0_addr = r0_addr + 1'b1;
                if (np == 1024) r0_valid = 0;
            end
            if (np > 0 && np < 1024 && !mem_valid) drops++;
        end
        chk("a_pulses", 32'(np), 32'd1024);
        chk("a_mem_valid_drops", 32'(drops), 32'd0);
        chk("a_end_addr", 32'(r0_addr), 32'(FLASH_GAME_BASE) + 32'd1024);
        mem_ready = 0;
        repeat (3) cycle();

        // Phase B: both requesters valid from reset, random flash timing plus stray mem_ready.
        reset = 1; r0_valid = 1; r1_valid = 1;
        r0_addr = AW'($urandom); r1_addr = AW'($urandom);
        cycle();
        reset = 0; lows = 0;
        for (int cyc = 0; cyc < 400 && seq.size() < 16; cyc++) begin
            mem_ready = (m_st == 1) ? 1'($urandom % 2) : ($urandom % 3 == 0);
            mem_rdata = 8'($urandom);
            cycle();
            if (e0) begin seq.push_back(0); r0_addr = AW'($urandom); end
            if (e1) begin seq.push_back(1); r1_addr = AW'($urandom); end
            if (seq.size() > 0 && seq.size() < 16 && !mem_valid) lows++;
        end
        chk("b_pulses", 32'(seq.size()), 32'd16);
        foreach (seq[i]) chk($sformatf("b_seq%0d", i), 32'(seq[i]), 32'((i / MB) % 2));
        chk("b_switch_gaps", 32'(lows), 32'd3);
`ifdef FLASH_ARB_STATS_EN
        chk("b_stat_grants0", grants0, 32'd8);
        chk("b_stat_grants1", grants1, 32'd8);
`endif

        // Phase C: r0 alone, drops its request mid-transfer; byte must vanish, arbiter idles.
        reset = 1; r1_valid = 0; r0_valid = 0; mem_ready = 0;
        cycle();
        reset = 0; r0_valid = 1; r0_addr = AW'($urandom);
        cycle();
        r0_valid = 0;
        cycle();
        cycle();
        chk("c_held", 32'(mem_valid), 32'd1);
        mem_ready = 1;
        cycle();
        chk("c_discard", 32'(e0), 32'd0);
        mem_ready = 0;
        cycle();
        chk("c_idle", 32'(mem_valid), 32'd0);

        // Phase D: reset lands while r1 owns the port with a completion in flight.
        r1_valid = 1; r1_addr = AW'($urandom);
        cycle();
        cycle();
        chk("d_r1_owner", 32'(m_own), 32'd1);
        reset = 1; mem_ready = 1;
        cycle();
        chk("d_mv_dropped", 32'(mem_valid), 32'd0);
        chk("d_owner_rst", 32'(owner), 32'd1);
        reset = 0; r1_valid = 0; mem_ready = 0;
        cycle();

        // Phase E: random traffic with drops, stray completions and occasional resets.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            reset = ($urandom % 300 == 0);
            if (r0_valid) begin
                if (e0) begin r0_valid = ($urandom % 4 != 0); r0_addr = AW'($urandom); end
                else if ($urandom % 100 == 0) r0_valid = 0;
            end else if ($urandom % 3 == 0) begin
                r0_valid = 1; r0_addr = AW'($urandom);
            end
            if (r1_valid) begin
                if (e1) begin r1_valid = ($urandom % 4 != 0); r1_addr = AW'($urandom); end
                else if ($urandom % 100 == 0) r1_valid = 0;
            end else if ($urandom % 3 == 0) begin
                r1_valid = 1; r1_addr = AW'($urandom);
            end
            mem_ready = (m_st == 1) ? ($urandom % 3 == 0) : ($urandom % 8 == 0);
            mem_rdata = 8'($urandom);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
